// File: rtl/piso_tx_pkg.sv
// Package: piso_tx_pkg
// Shared types and constants for the framed parallel-in/serial-out transmitter.
// The optional parity bit is enabled by defining PISO_TX_PARITY_EN.
package piso_tx_pkg;

   // Frame sequencer states. PARITY is only visited when PISO_TX_PARITY_EN is defined.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   // Line levels: the line rests high, a frame begins with a low start bit.
   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

   // Counter width helper: $clog2 but never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Serial bits in one frame: start + data + optional parity + stop.
   function automatic int frame_bits(input int width, input bit parity_en);
      return width + 2 + (parity_en ? 1 : 0);
   endfunction

   // Clock cycles from accept edge to the done pulse.
   function automatic int frame_clks(input int width, input int clks_per_bit, input bit parity_en);
      return frame_bits(width, parity_en) * clks_per_bit;
   endfunction

endpackage

// File: rtl/piso_serial_tx_if.sv
// Interface: piso_serial_tx_if
// Word handshake into the serial transmitter.
// Handshake: the master presents tx_data with tx_valid; the slave raises tx_ready
// only when idle. A word is transferred on the rising clk where tx_valid and
// tx_ready are both 1; tx_data is sampled only on that edge, and tx_valid or
// tx_data changes while tx_ready is 0 have no effect.
interface piso_serial_tx_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] tx_data;
   logic             tx_valid;
   logic             tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/piso_bit_timer.sv
// Module: piso_bit_timer
// Counts CLKS_PER_BIT cycles per serial bit and flags the last cycle of each bit.
// The count restarts at zero on a word accept so the first bit is full length.
module piso_bit_timer
   import piso_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   input  logic enable,
   output logic bit_tick
);

   localparam int CNT_W = clog2_min1(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   // Last cycle of the current bit; only meaningful while a frame is running.
   assign bit_tick = enable & (cnt == LAST_CNT);

   // Cycle counter: cleared on restart, when idle, and at the end of every bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (restart || !enable || bit_tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/piso_serial_tx.sv
// Module: piso_serial_tx
// Framed serial transmitter: start bit, WIDTH data bits LSB first, optional even
// parity bit, stop bit; every bit held for CLKS_PER_BIT clocks on a registered line.
// Define PISO_TX_PARITY_EN to insert the parity bit between data and stop.
module piso_serial_tx
   import piso_tx_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic            clk,
   input  logic            reset,
   piso_serial_tx_if.slave tx,
   output logic            sout,
   output logic            busy,
   output logic            done,
   output tx_state_e       state_dbg
);

   localparam int IDX_W = clog2_min1(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   tx_state_e        state;
   logic [WIDTH-1:0] shreg;
   logic [IDX_W-1:0] bit_idx;
   logic             tx_ready_q;
   logic             accept;
   logic             bit_tick;
   logic             timer_en;
   logic             next_bit;
`ifdef PISO_TX_PARITY_EN
   logic             parity_bit;
`endif

   assign accept      = tx.tx_valid & tx_ready_q;
   assign tx.tx_ready = tx_ready_q;
   assign timer_en    = (state != IDLE);
   assign state_dbg   = state;

   // Data bit that follows the current one; a 1-bit word has no successor.
   generate
      if (WIDTH > 1) begin : g_next_bit
         assign next_bit = shreg[1];
      end else begin : g_single_bit
         assign next_bit = IDLE_LEVEL;
      end
   endgenerate

   piso_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk      (clk),
      .reset    (reset),
      .restart  (accept),
      .enable   (timer_en),
      .bit_tick (bit_tick)
   );

   // Frame sequencer; the line level and handshake outputs are registered here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         sout       <= IDLE_LEVEL;
         tx_ready_q <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         shreg      <= '0;
         bit_idx    <= '0;
`ifdef PISO_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  shreg      <= tx.tx_data;
                  bit_idx    <= '0;
                  state      <= START;
                  sout       <= START_LEVEL;
                  tx_ready_q <= 1'b0;
                  busy       <= 1'b1;
`ifdef PISO_TX_PARITY_EN
                  parity_bit <= ^tx.tx_data;
`endif
               end
            end
            START: begin
               if (bit_tick) begin
                  state <= DATA;
                  sout  <= shreg[0];
               end
            end
            DATA: begin
               if (bit_tick) begin
                  shreg <= shreg >> 1;
                  if (bit_idx == LAST_IDX) begin
                     bit_idx <= '0;
`ifdef PISO_TX_PARITY_EN
                     state   <= PARITY;
                     sout    <= parity_bit;
`else
                     state   <= STOP;
                     sout    <= IDLE_LEVEL;
`endif
                  end else begin
                     bit_idx <= bit_idx + IDX_W'(1);
                     sout    <= next_bit;
                  end
               end
            end
`ifdef PISO_TX_PARITY_EN
            PARITY: begin
               if (bit_tick) begin
                  state <= STOP;
                  sout  <= IDLE_LEVEL;
               end
            end
`endif
            STOP: begin
               if (bit_tick) begin
                  state      <= IDLE;
                  done       <= 1'b1;
                  tx_ready_q <= 1'b1;
                  busy       <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               sout       <= IDLE_LEVEL;
               tx_ready_q <= 1'b1;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Testbench: tb_piso_serial_tx
// Directed and random frames checked cycle by cycle against a frame model built
// from the bit list start / data LSB first / optional even parity / stop.
// Honors PISO_TX_PARITY_EN the same way the design does.
module tb_piso_serial_tx;

   localparam int WIDTH = 8;
   localparam int CPB   = 4;
`ifdef PISO_TX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int FRAME_CLKS = (WIDTH + 2 + PAR_BITS) * CPB;

   logic clk = 1'b0;
   logic reset;
   logic sout;
   logic busy;
   logic done;
   piso_tx_pkg::tx_state_e state_dbg;

   int vectors     = 0;
   int miscompares = 0;

   piso_serial_tx_if #(.WIDTH(WIDTH)) tx_if ();

   piso_serial_tx #(
      .WIDTH        (WIDTH),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .tx        (tx_if.slave),
      .sout      (sout),
      .busy      (busy),
      .done      (done),
      .state_dbg (state_dbg)
   );

   // Clock: 6 ns period
   always #3 clk = ~clk;

   // Watchdog
   initial begin
      #200us;
      $display("FAIL watchdog: simulation still running at 200us, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".sout"},     32'(sout),           32'd1);
      check({tag, ".tx_ready"}, 32'(tx_if.tx_ready), 32'd1);
      check({tag, ".busy"},     32'(busy),           32'd0);
      check({tag, ".done"},     32'(done),           32'd0);
   endtask

   // Expected line level for each serial bit of a frame carrying d.
   task automatic build_frame(input logic [WIDTH-1:0] d, output logic [0:0] exp_q[$]);
      exp_q = {};
      exp_q.push_back(1'b0);
      for (int i = 0; i < WIDTH; i++) exp_q.push_back(d[i]);
      if (PAR_BITS == 1) exp_q.push_back(^d);
      exp_q.push_back(1'b1);
   endtask

   // Called at a negedge with the transmitter idle. Sends d and checks every cycle
   // through the done cycle. keep_valid leaves tx_valid high afterwards; disturb
   // toggles tx_valid and scribbles tx_data while the frame is in flight.
   task automatic run_frame(input string name, input logic [WIDTH-1:0] d,
                            input bit keep_valid, input bit disturb);
      logic [0:0] exp_q[$];
      build_frame(d, exp_q);
      tx_if.tx_data  = d;
      tx_if.tx_valid = 1'b1;
      check({name, ".ready_pre"}, 32'(tx_if.tx_ready), 32'd1);
      @(posedge clk);
      for (int k = 0; k < FRAME_CLKS; k++) begin
         @(negedge clk);
         if (disturb) begin
            tx_if.tx_valid = 1'($urandom_range(0, 1));
            tx_if.tx_data  = (k % 3 == 0) ? 8'hFF : 8'($urandom);
         end else if (!keep_valid) begin
            tx_if.tx_valid = 1'b0;
         end
         check($sformatf("%s.sout[%0d]", name, k),  32'(sout),           32'(exp_q[k / CPB]));
         check($sformatf("%s.ready[%0d]", name, k), 32'(tx_if.tx_ready), 32'd0);
         check($sformatf("%s.busy[%0d]", name, k),  32'(busy),           32'd1);
         check($sformatf("%s.done[%0d]", name, k),  32'(done),           32'd0);
      end
      @(negedge clk);
      if (!keep_valid) tx_if.tx_valid = 1'b0;
      check({name, ".done_pulse"}, 32'(done),           32'd1);
      check({name, ".ready_end"},  32'(tx_if.tx_ready), 32'd1);
      check({name, ".busy_end"},   32'(busy),           32'd0);
      check({name, ".sout_end"},   32'(sout),           32'd1);
   endtask

   initial begin
      logic [WIDTH-1:0] rd;
      bit               rk;
      logic [0:0]       exp_q[$];

      // Reset held for 8 ns with no traffic
      reset          = 1'b1;
      tx_if.tx_valid = 1'b0;
      tx_if.tx_data  = '0;
      #1 check_idle("rst_t1");
      #3 check_idle("rst_t4");
      #3 check_idle("rst_t7");
      #1 reset = 1'b0;
      @(negedge clk);
      check_idle("post_rst");
      @(negedge clk);
      check_idle("post_rst2");

      // Single frame 8'hA5
      run_frame("a5", 8'hA5, 1'b0, 1'b0);
      @(negedge clk);
      check_idle("a5_after");

      // Back-to-back with tx_valid held: 00 then FF, one idle cycle between
      run_frame("b2b_00", 8'h00, 1'b1, 1'b0);
      run_frame("b2b_ff", 8'hFF, 1'b0, 1'b0);
      @(negedge clk);
      check_idle("b2b_after");

      // Reset during data bit 3 of 8'hA5, then 8'h3C
      build_frame(8'hA5, exp_q);
      tx_if.tx_data  = 8'hA5;
      tx_if.tx_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tx_if.tx_valid = 1'b0;
      for (int k = 1; k <= 17; k++) @(negedge clk);
      check("rstmid.sout_bit3", 32'(sout), 32'(exp_q[4]));
      check("rstmid.busy_pre", 32'(busy), 32'd1);
      #1 reset = 1'b1;
      #1 check_idle("rstmid.async");
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < FRAME_CLKS; k++) begin
         @(negedge clk);
         check_idle($sformatf("rstmid.quiet[%0d]", k));
      end
      run_frame("f3c", 8'h3C, 1'b0, 1'b0);
      @(negedge clk);
      check_idle("f3c_after");

      // tx_valid toggled and tx_data changed while busy
      run_frame("disturb", 8'hA5, 1'b0, 1'b1);
      @(negedge clk);
      check_idle("disturb_after");

      // Random words, random back-to-back and idle gaps
      for (int n = 0; n < 8; n++) begin
         rd = 8'($urandom);
         rk = 1'($urandom_range(0, 1));
         run_frame($sformatf("rnd%0d", n), rd, rk, 1'($urandom_range(0, 1)));
         if (!rk) begin
            tx_if.tx_valid = 1'b0;
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
               @(negedge clk);
               check_idle($sformatf("rnd%0d.gap%0d", n, g));
            end
         end
      end
      tx_if.tx_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_idle("final");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
